// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle CPU sequencer.
// Nineteen sequencer states need a 5-bit state register.
package cpu_pkg;

    localparam int CTRL_STATE_W = 5;

    typedef enum logic [CTRL_STATE_W-1:0] {
        S_RST     = 5'd0,
        S_IF1     = 5'd1,
        S_IF2     = 5'd2,
        S_UPD_PC  = 5'd3,
        S_DECODE  = 5'd4,
        S_GET_A   = 5'd5,
        S_GET_B   = 5'd6,
        S_ALU     = 5'd7,
        S_SH_ALU  = 5'd8,
        S_CMP     = 5'd9,
        S_WR_REG  = 5'd10,
        S_WR_IMM  = 5'd11,
        S_ADDR    = 5'd12,
        S_LD_ADDR = 5'd13,
        S_MEM_RD  = 5'd14,
        S_MEM_WB  = 5'd15,
        S_GET_RD  = 5'd16,
        S_MEM_WR  = 5'd17,
        S_HALT    = 5'd18
    } ctrl_state_t;

    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_LDR  = 3'b011;
    localparam logic [2:0] OP_STR  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] MOV_SHIFT = 2'b00;
    localparam logic [1:0] MOV_IMM   = 2'b10;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_AND   = 2'b10;
    localparam logic [1:0] ALU_MVN   = 2'b11;
    localparam logic [1:0] MEMOP     = 2'b00;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [2:0] NSEL_RM = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RN = 3'b100;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

endpackage

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle CPU sequencer: fetch, decode, execute, memory and write-back.
// Outputs are Moore, decoded from the state register only.
//
// state     | meaning
// RST       | PC <- 0
// IF1/IF2   | instruction read, IR captured in IF2
// UPD_PC    | PC <- PC + 1
// DECODE    | branch on opcode/op
// GET_A/B   | load A (Rn) / B (Rm)
// ALU       | C <- A op B
// SH_ALU    | C <- 0 op shifted B
// CMP       | status <- A - B
// WR_REG    | Rd <- C
// WR_IMM    | Rn <- sximm8
// ADDR      | C <- A + sximm5
// LD_ADDR   | data address <- C
// MEM_RD/WB | data read, Rd <- mdata
// GET_RD    | B <- Rd (store data)
// MEM_WR    | memory write
// HALT      | stopped until reset
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int STATE_W = CTRL_STATE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         opcode,
    input  logic [1:0]         op,
    output logic               reset_pc,
    output logic               load_pc,
    output logic               addr_sel,
    output logic               load_ir,
    output logic               load_addr,
    output logic [1:0]         mem_cmd,
    output logic [1:0]         vsel,
    output logic [2:0]         nsel,
    output logic               write,
    output logic               loada,
    output logic               loadb,
    output logic               loadc,
    output logic               loads,
    output logic               asel,
    output logic               bsel,
    output logic               halted,
    output logic [STATE_W-1:0] state
);

    ctrl_state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_RST;
        else        state_q <= state_d;
    end

    // opcode/op stay stable after IF2, so later states may branch on them too
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_IF1;
            S_IF1:    state_d = S_IF2;
            S_IF2:    state_d = S_UPD_PC;
            S_UPD_PC: state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_IF1;
                case (opcode)
                    OP_MOV: begin
                        if (op == MOV_IMM)        state_d = S_WR_IMM;
                        else if (op == MOV_SHIFT) state_d = S_GET_B;
                    end
                    OP_ALU:  state_d = (op == ALU_MVN) ? S_GET_B : S_GET_A;
                    OP_LDR:  if (op == MEMOP) state_d = S_GET_A;
                    OP_STR:  if (op == MEMOP) state_d = S_GET_A;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_IF1;
                endcase
            end
            S_GET_A:   state_d = (opcode == OP_LDR || opcode == OP_STR) ? S_ADDR : S_GET_B;
            S_GET_B: begin
                if (opcode == OP_ALU && op == ALU_CMP)      state_d = S_CMP;
                else if (opcode == OP_ALU && op != ALU_MVN) state_d = S_ALU;
                else                                        state_d = S_SH_ALU;
            end
            S_ALU:     state_d = S_WR_REG;
            S_SH_ALU:  state_d = (opcode == OP_STR) ? S_MEM_WR : S_WR_REG;
            S_CMP:     state_d = S_IF1;
            S_WR_REG:  state_d = S_IF1;
            S_WR_IMM:  state_d = S_IF1;
            S_ADDR:    state_d = S_LD_ADDR;
            S_LD_ADDR: state_d = (opcode == OP_STR) ? S_GET_RD : S_MEM_RD;
            S_MEM_RD:  state_d = S_MEM_WB;
            S_MEM_WB:  state_d = S_IF1;
            S_GET_RD:  state_d = S_SH_ALU;
            S_MEM_WR:  state_d = S_IF1;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_RST;
        endcase
    end

    always_comb begin
        reset_pc  = 1'b0;
        load_pc   = 1'b0;
        addr_sel  = 1'b0;
        load_ir   = 1'b0;
        load_addr = 1'b0;
        mem_cmd   = MEM_NONE;
        vsel      = VSEL_C;
        nsel      = 3'b000;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_RST:     begin reset_pc = 1'b1; load_pc = 1'b1; end
            S_IF1:     begin addr_sel = 1'b1; mem_cmd = MEM_READ; end
            S_IF2:     begin addr_sel = 1'b1; mem_cmd = MEM_READ; load_ir = 1'b1; end
            S_UPD_PC:  load_pc = 1'b1;
            S_GET_A:   begin nsel = NSEL_RN; loada = 1'b1; end
            S_GET_B:   begin nsel = NSEL_RM; loadb = 1'b1; end
            S_ALU:     loadc = 1'b1;
            S_SH_ALU:  begin loadc = 1'b1; asel = 1'b1; end
            S_CMP:     loads = 1'b1;
            S_WR_REG:  begin nsel = NSEL_RD; vsel = VSEL_C; write = 1'b1; end
            S_WR_IMM:  begin nsel = NSEL_RN; vsel = VSEL_IMM; write = 1'b1; end
            S_ADDR:    begin loadc = 1'b1; bsel = 1'b1; end
            S_LD_ADDR: load_addr = 1'b1;
            S_MEM_RD:  mem_cmd = MEM_READ;
            S_MEM_WB: begin
                mem_cmd = MEM_READ;
                nsel    = NSEL_RD;
                vsel    = VSEL_MDATA;
                write   = 1'b1;
            end
            S_GET_RD:  begin nsel = NSEL_RD; loadb = 1'b1; end
            S_MEM_WR:  mem_cmd = MEM_WRITE;
            S_HALT:    halted = 1'b1;
            default:   ;
        endcase
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: instruction table plus hand-written
// reset/HALT sequences, with expected states queued and compared per cycle.
module tb_cpu_seq_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic        reset_pc, load_pc, addr_sel, load_ir, load_addr;
    logic [1:0]  mem_cmd, vsel;
    logic [2:0]  nsel;
    logic        write, loada, loadb, loadc, loads, asel, bsel, halted;
    logic [CTRL_STATE_W-1:0] state;

    cpu_seq_ctrl #(.STATE_W(CTRL_STATE_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op),
        .reset_pc(reset_pc), .load_pc(load_pc), .addr_sel(addr_sel),
        .load_ir(load_ir), .load_addr(load_addr), .mem_cmd(mem_cmd),
        .vsel(vsel), .nsel(nsel), .write(write), .loada(loada),
        .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel),
        .bsel(bsel), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       reset_pc, load_pc, addr_sel, load_ir, load_addr;
        logic [1:0] mem_cmd, vsel;
        logic [2:0] nsel;
        logic       write, loada, loadb, loadc, loads, asel, bsel, halted;
    } out_t;

    out_t act;
    assign act = {reset_pc, load_pc, addr_sel, load_ir, load_addr, mem_cmd, vsel,
                  nsel, write, loada, loadb, loadc, loads, asel, bsel, halted};

    typedef struct {
        string       name;
        logic [2:0]  opcode;
        logic [1:0]  op;
        int          cycles;
        int          n;
        ctrl_state_t path [6];
    } vec_t;

    vec_t        vecs [$];
    ctrl_state_t exp_q [$];
    int          errors = 0;
    int          checks = 0;

    function automatic out_t exp_out(ctrl_state_t s);
        out_t o = '0;
        case (s)
            S_RST:     begin o.reset_pc = 1; o.load_pc = 1; end
            S_IF1:     begin o.addr_sel = 1; o.mem_cmd = 2'b01; end
            S_IF2:     begin o.addr_sel = 1; o.mem_cmd = 2'b01; o.load_ir = 1; end
            S_UPD_PC:  o.load_pc = 1;
            S_GET_A:   begin o.nsel = 3'b100; o.loada = 1; end
            S_GET_B:   begin o.nsel = 3'b001; o.loadb = 1; end
            S_ALU:     o.loadc = 1;
            S_SH_ALU:  begin o.loadc = 1; o.asel = 1; end
            S_CMP:     o.loads = 1;
            S_WR_REG:  begin o.nsel = 3'b010; o.vsel = 2'b00; o.write = 1; end
            S_WR_IMM:  begin o.nsel = 3'b100; o.vsel = 2'b10; o.write = 1; end
            S_ADDR:    begin o.loadc = 1; o.bsel = 1; end
            S_LD_ADDR: o.load_addr = 1;
            S_MEM_RD:  o.mem_cmd = 2'b01;
            S_MEM_WB:  begin o.mem_cmd = 2'b01; o.nsel = 3'b010; o.vsel = 2'b11; o.write = 1; end
            S_GET_RD:  begin o.nsel = 3'b010; o.loadb = 1; end
            S_MEM_WR:  o.mem_cmd = 2'b10;
            S_HALT:    o.halted = 1;
            default:   o = '0;
        endcase
        return o;
    endfunction

    task automatic check(input string name, input ctrl_state_t es);
        out_t eo;
        eo = exp_out(es);
        checks++;
        if (state !== es) begin
            errors++;
            $display("FAIL %s state: got %0d required %0d", name, state, es);
        end
        checks++;
        if (act !== eo) begin
            errors++;
            $display("FAIL %s outputs (state %0d): got %05h required %05h", name, es, act, eo);
        end
    endtask

    task automatic add_vec(input string nm, input logic [2:0] oc, input logic [1:0] o,
                           input int cyc, input int n,
                           input ctrl_state_t p0, input ctrl_state_t p1, input ctrl_state_t p2,
                           input ctrl_state_t p3, input ctrl_state_t p4, input ctrl_state_t p5);
        vec_t v;
        v.name = nm; v.opcode = oc; v.op = o; v.cycles = cyc; v.n = n;
        v.path[0] = p0; v.path[1] = p1; v.path[2] = p2;
        v.path[3] = p3; v.path[4] = p4; v.path[5] = p5;
        vecs.push_back(v);
    endtask

    task automatic push_fetch();
        exp_q.push_back(S_IF2);
        exp_q.push_back(S_UPD_PC);
        exp_q.push_back(S_DECODE);
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            check(name, exp_q.pop_front());
        end
    endtask

    // Starts at a negedge in IF1; measures edges until the next IF1.
    task automatic run_vec(input vec_t v);
        int cyc;
        opcode = v.opcode;
        op     = v.op;
        push_fetch();
        for (int k = 0; k < v.n; k++) exp_q.push_back(v.path[k]);
        exp_q.push_back(S_IF1);
        cyc = 0;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) check(v.name, exp_q.pop_front());
            if (state == S_IF1) break;
        end
        checks++;
        if (cyc != v.cycles) begin
            errors++;
            $display("FAIL %s cycles: got %0d required %0d", v.name, cyc, v.cycles);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s path: %0d expected states never reached", v.name, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        add_vec("mov_imm",   3'b110, 2'b10, 5, 1, S_WR_IMM, S_RST, S_RST, S_RST, S_RST, S_RST);
        add_vec("mov_shift", 3'b110, 2'b00, 7, 3, S_GET_B, S_SH_ALU, S_WR_REG, S_RST, S_RST, S_RST);
        add_vec("add",       3'b101, 2'b00, 8, 4, S_GET_A, S_GET_B, S_ALU, S_WR_REG, S_RST, S_RST);
        add_vec("cmp",       3'b101, 2'b01, 7, 3, S_GET_A, S_GET_B, S_CMP, S_RST, S_RST, S_RST);
        add_vec("and",       3'b101, 2'b10, 8, 4, S_GET_A, S_GET_B, S_ALU, S_WR_REG, S_RST, S_RST);
        add_vec("mvn",       3'b101, 2'b11, 7, 3, S_GET_B, S_SH_ALU, S_WR_REG, S_RST, S_RST, S_RST);
        add_vec("ldr",       3'b011, 2'b00, 9, 5, S_GET_A, S_ADDR, S_LD_ADDR, S_MEM_RD, S_MEM_WB, S_RST);
        add_vec("str",       3'b100, 2'b00, 10, 6, S_GET_A, S_ADDR, S_LD_ADDR, S_GET_RD, S_SH_ALU, S_MEM_WR);
        add_vec("nop_000",   3'b000, 2'b00, 4, 0, S_RST, S_RST, S_RST, S_RST, S_RST, S_RST);
        add_vec("nop_ldr01", 3'b011, 2'b01, 4, 0, S_RST, S_RST, S_RST, S_RST, S_RST, S_RST);
        add_vec("nop_mov01", 3'b110, 2'b01, 4, 0, S_RST, S_RST, S_RST, S_RST, S_RST, S_RST);
        add_vec("nop_str11", 3'b100, 2'b11, 4, 0, S_RST, S_RST, S_RST, S_RST, S_RST, S_RST);

        reset  = 1'b0;
        opcode = 3'b000;
        op     = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hold", S_RST);
        reset = 1'b1;
        @(negedge clk);
        check("reset_release", S_IF1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during LD_ADDR: the LDR must be abandoned before MEM_RD/MEM_WB.
        opcode = 3'b011;
        op     = 2'b00;
        push_fetch();
        exp_q.push_back(S_GET_A);
        exp_q.push_back(S_ADDR);
        exp_q.push_back(S_LD_ADDR);
        drain("ldr_pre_reset");
        reset = 1'b0;
        @(negedge clk);
        check("ldr_mid_reset", S_RST);
        checks++;
        if (write !== 1'b0 || load_ir !== 1'b0 || mem_cmd === 2'b10) begin
            errors++;
            $display("FAIL ldr_mid_reset commit: got write=%b load_ir=%b mem_cmd=%b required 0/0/not 10",
                     write, load_ir, mem_cmd);
        end
        reset  = 1'b1;
        opcode = 3'b000;
        @(negedge clk);
        check("ldr_mid_reset_if1", S_IF1);
        run_vec(vecs[0]);

        // HALT holds until reset.
        opcode = 3'b111;
        op     = 2'b10;
        push_fetch();
        exp_q.push_back(S_HALT);
        drain("halt_enter");
        repeat (22) begin
            @(negedge clk);
            check("halt_hold", S_HALT);
        end
        reset = 1'b0;
        @(negedge clk);
        check("halt_reset", S_RST);
        reset  = 1'b1;
        opcode = 3'b000;
        @(negedge clk);
        check("halt_reset_if1", S_IF1);
        run_vec(vecs[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
